cory_burst_pass: RTL and testbench
==================================

Name: cory_burst_pass

Overview:
- Upstream gating stage that admits exactly a programmed number of beats per go command and then blocks.
- Produces a bounded, last-tagged burst on a registered valid/ready output, for a downstream pass/queue stage to consume.
- Reports busy and completion so a controller can sequence bursts.

Parameters:
N, 8, data width of i_a_d / o_z_d
W, 8, width of burst length i_len and count o_cnt (max burst 2^W-1)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
i_go  input  1  start command, sampled only in IDLE
i_len  input  W  beats in burst, sampled with i_go
o_busy  output  1  high whenever state != IDLE
o_done  output  1  one-cycle completion pulse
o_cnt  output  W  beats accepted so far in current burst
i_a_v  input  1  upstream valid
i_a_d  input  N  upstream data
o_a_r  output  1  upstream ready
o_z_v  output  1  downstream valid (registered)
o_z_d  output  N  downstream data (registered)
o_z_last  output  1  marks final beat of burst, qualified by o_z_v
i_z_r  input  1  downstream ready

Behaviour:
- Reset (reset=1 at clk edge): state=IDLE, o_z_v=0, o_z_last=0, o_done=0, o_cnt=0, o_busy=0, remaining=0. o_z_d is don't-care but cleared to 0. Any in-flight beat is dropped. Reset mid-burst returns to IDLE with no done pulse.
- Transfer definitions: accept = i_a_v & o_a_r; emit = o_z_v & i_z_r.
- States: IDLE, PASS, DRAIN.
- IDLE:
  - o_a_r=0.
  - i_go=1 and i_len!=0: load remaining=i_len, clear o_cnt, go to PASS.
  - i_go=1 and i_len==0: no state change; o_done=1 on next cycle.
- PASS:
  - o_a_r = (remaining!=0) & (!o_z_v | i_z_r). Output is a one-entry register, so a beat can be accepted in the same cycle the held beat is emitted.
  - On accept: o_z_d<=i_a_d, o_z_v<=1, remaining--, o_cnt++. o_z_last<=1 iff remaining==1 before the decrement.
  - On emit without accept: o_z_v<=0.
  - When the last beat is accepted, go to DRAIN.
- DRAIN:
  - o_a_r=0.
  - When emit occurs on the last beat: o_z_v<=0, go to IDLE, o_done<=1 for exactly one cycle (the first IDLE cycle).
- o_done cycle: i_go is accepted in the same cycle, so back-to-back bursts lose only one bubble cycle.
- i_go while busy: ignored; i_len is not resampled.
- Latency: data appears on o_z_* one cycle after accept. Throughput is 1 beat/cycle while i_z_r=1.
- Downstream stall: o_z_v/o_z_d/o_z_last hold stable while o_z_v=1 & i_z_r=0. o_a_r=0 during the stall.
- o_z_last=1 only on the beat numbered i_len; cleared on emit.
- o_cnt saturates naturally at i_len (never exceeds it). It holds its value in IDLE until the next accepted i_go.
- Width rule: remaining and o_cnt are W bits; i_len=2^W-1 must work without wrap.
- Upstream beats offered in IDLE/DRAIN are never consumed. i_a_v without o_a_r is not an error.

Test Plan:
- Reset, then i_go=1, i_len=3; source offers D0..D5 continuously; i_z_r=1. Required: o_z emits D0,D1,D2 on consecutive cycles, o_z_last only on D2. o_a_r low after third accept, D3 not consumed. o_done pulses exactly once, one cycle after D2 emits. o_cnt=3.
- i_len=4 with i_z_r toggling 1,0,0,1,... Required: o_z_d stable during stalls, no beat lost or duplicated, output sequence D0..D3, done only after D3 emits.
- i_go=1 with i_len=0. Required: o_busy stays 0, o_done=1 for one cycle next cycle, o_a_r never asserts.
- Back-to-back: i_len=2, then i_go held high with i_len=5. Required: second burst starts on the o_done cycle, 7 beats total, o_z_last on beats 2 and 7, an i_go pulse during the first burst is ignored.
- W=4, i_len=15, continuous traffic. Required: exactly 15 beats, o_cnt reaches 15 without wrap.
- Assert reset during PASS after 2 of 5 beats, with o_z_v=1. Required: next cycle o_z_v=0, o_busy=0, o_cnt=0, no o_done. A new i_go i_len=1 completes normally.

Source files
------------

// File: rtl/cory_burst_pass.sv
// ---------------------------------------------------------------------------
// cory_burst_pass
//
// Upstream gating stage. Each accepted go command admits exactly i_len beats
// from the upstream valid/ready port, forwards them through a one-entry
// registered output slot tagged with last on the final beat, then blocks
// upstream until that final beat has been taken downstream.
//
// Ports:
//   clk       clock, all logic on the rising edge
//   reset     synchronous active-high reset
//   i_go      start command, only honoured while idle
//   i_len     burst length in beats, sampled together with i_go
//   o_busy    high whenever a burst is in progress
//   o_done    one-cycle pulse after the final beat leaves (or after a
//             zero-length go)
//   o_cnt     beats accepted so far in the current/last burst
//   i_a_v     upstream valid
//   i_a_d     upstream data
//   o_a_r     upstream ready
//   o_z_v     downstream valid (registered)
//   o_z_d     downstream data (registered)
//   o_z_last  final beat marker, qualified by o_z_v
//   i_z_r     downstream ready
// ---------------------------------------------------------------------------
module cory_burst_pass #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_go,
  input  logic [W-1:0] i_len,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_cnt,
  input  logic         i_a_v,
  input  logic [N-1:0] i_a_d,
  output logic         o_a_r,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  output logic         o_z_last,
  input  logic         i_z_r
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] rem_q,   rem_d;
  logic [W-1:0] cnt_q,   cnt_d;
  logic         zv_q,    zv_d;
  logic [N-1:0] zd_q,    zd_d;
  logic         zl_q,    zl_d;
  logic         done_q,  done_d;

  logic         a_r;
  logic         accept;
  logic         emit;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    zv_d    = zv_q;
    zd_d    = zd_q;
    zl_d    = zl_q;
    done_d  = 1'b0;
    a_r     = 1'b0;
    emit    = zv_q & i_z_r;

    case (state_q)
      IDLE: begin
        if (i_go) begin
          if (i_len != '0) begin
            rem_d   = i_len;
            cnt_d   = '0;
            state_d = PASS;
          end else begin
            // Zero-length burst completes immediately without going busy.
            done_d = 1'b1;
          end
        end
      end
      PASS: begin
        // The output slot can be refilled in the same cycle it is emptied.
        a_r = (rem_q != '0) & (~zv_q | i_z_r);
      end
      DRAIN: begin
        // Only the final beat can be held here.
        if (emit) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    accept = i_a_v & a_r;

    if (emit) begin
      zv_d = 1'b0;
      zl_d = 1'b0;
    end

    // Accept takes priority over the emit clear above: a fresh beat lands
    // in the slot that is being vacated.
    if (accept) begin
      zd_d  = i_a_d;
      zv_d  = 1'b1;
      zl_d  = (rem_q == W'(1));
      rem_d = rem_q - W'(1);
      cnt_d = cnt_q + W'(1);
      if (rem_q == W'(1)) begin
        state_d = DRAIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      zv_q    <= 1'b0;
      zd_q    <= '0;
      zl_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      zv_q    <= zv_d;
      zd_q    <= zd_d;
      zl_q    <= zl_d;
      done_q  <= done_d;
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_done   = done_q;
  assign o_cnt    = cnt_q;
  assign o_a_r    = a_r;
  assign o_z_v    = zv_q;
  assign o_z_d    = zd_q;
  assign o_z_last = zl_q;

endmodule

// File: tb/tb_cory_burst_pass.sv
// ---------------------------------------------------------------------------
// tb_cory_burst_pass
//
// Bench for cory_burst_pass. A behavioural model tracks busy/remaining/count;
// beats are pushed to a scoreboard queue when an accept is expected and
// popped/compared when the output is emitted. A second instance with W=4
// shares the stimulus to exercise the maximum 4-bit burst length.
// ---------------------------------------------------------------------------
module tb_cory_burst_pass;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_go;
  logic [7:0] i_len;
  logic       o_busy, o_done;
  logic [7:0] o_cnt;
  logic       i_a_v;
  logic [7:0] i_a_d;
  logic       o_a_r, o_z_v, o_z_last;
  logic [7:0] o_z_d;
  logic       i_z_r;

  logic       d4_busy, d4_done, d4_a_r, d4_z_v, d4_z_last;
  logic [3:0] d4_cnt;
  logic [3:0] d4_len;
  logic [7:0] d4_z_d;

  always #5 clk = ~clk;

  assign d4_len = i_len[3:0];

  cory_burst_pass #(.N(8), .W(8)) u_dut (
    .clk(clk), .reset(reset), .i_go(i_go), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done), .o_cnt(o_cnt),
    .i_a_v(i_a_v), .i_a_d(i_a_d), .o_a_r(o_a_r),
    .o_z_v(o_z_v), .o_z_d(o_z_d), .o_z_last(o_z_last), .i_z_r(i_z_r)
  );

  cory_burst_pass #(.N(8), .W(4)) u_dut4 (
    .clk(clk), .reset(reset), .i_go(i_go), .i_len(d4_len),
    .o_busy(d4_busy), .o_done(d4_done), .o_cnt(d4_cnt),
    .i_a_v(i_a_v), .i_a_d(i_a_d), .o_a_r(d4_a_r),
    .o_z_v(d4_z_v), .o_z_d(d4_z_d), .o_z_last(d4_z_last), .i_z_r(i_z_r)
  );

  typedef struct {
    logic [7:0] d;
    logic       last;
  } beat_t;

  typedef struct {
    int len;
    bit stall;
    int exp_beats;
    int exp_cnt;
  } vec_t;

  beat_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         m_busy;
  int         m_rem;
  logic [7:0] m_cnt;
  bit         m_done;

  int n_beats, n_last, n_done, n4_beats, n4_last;
  bit stall_mode;
  int ph;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    n_beats = 0; n_last = 0; n_done = 0; n4_beats = 0; n4_last = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_go  = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset  = 1'b0;
    sb.delete();
    m_busy = 1'b0;
    m_rem  = 0;
    m_cnt  = 8'd0;
    m_done = 1'b0;
    ph     = 0;
  endtask

  // One clock: compare at the falling edge, advance model, then drive
  // new inputs just after the rising edge.
  task automatic tick();
    beat_t b;
    bit exp_ar, acc, emt, done_n, busy_n, go_seen;
    @(negedge clk);
    chk("busy", o_busy, m_busy);
    chk("done", o_done, m_done);
    chk("cnt",  o_cnt,  m_cnt);
    chk("z_v",  o_z_v,  sb.size() != 0);
    exp_ar = m_busy && (m_rem != 0) && (sb.size() == 0 || i_z_r);
    chk("a_r", o_a_r, exp_ar);
    if (sb.size() != 0) begin
      chk("z_d",    o_z_d,    sb[0].d);
      chk("z_last", o_z_last, sb[0].last);
    end
    if (o_done) n_done++;
    if (d4_z_v && i_z_r) begin
      n4_beats++;
      if (d4_z_last) n4_last++;
    end

    done_n  = 1'b0;
    busy_n  = m_busy;
    go_seen = 1'b0;
    emt     = (sb.size() != 0) && i_z_r;
    acc     = i_a_v && exp_ar;

    if (!m_busy && i_go) begin
      go_seen = 1'b1;
      if (i_len != 8'd0) begin
        busy_n = 1'b1;
        m_rem  = int'(i_len);
        m_cnt  = 8'd0;
      end else begin
        done_n = 1'b1;
      end
    end
    if (emt) begin
      b = sb.pop_front();
      n_beats++;
      if (b.last) begin
        n_last++;
        busy_n = 1'b0;
        done_n = 1'b1;
      end
    end
    if (acc) begin
      b.d    = i_a_d;
      b.last = (m_rem == 1);
      sb.push_back(b);
      m_rem--;
      m_cnt++;
    end
    m_busy = busy_n;
    m_done = done_n;

    @(posedge clk);
    #1;
    if (acc) i_a_d = i_a_d + 8'd1;
    if (go_seen) i_go = 1'b0;
    ph++;
    i_z_r = stall_mode ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
  endtask

  task automatic run_until(input int target_dones, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      tick();
      if (n_done >= target_dones && !m_busy && !i_go) break;
    end
    checks++;
    if (i >= bound) begin
      errors++;
      $display("FAIL timeout: dones %0d required %0d within %0d cycles", n_done, target_dones, bound);
    end
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{len: 3,   stall: 1'b0, exp_beats: 3,   exp_cnt: 3};
    vecs[1] = '{len: 4,   stall: 1'b1, exp_beats: 4,   exp_cnt: 4};
    vecs[2] = '{len: 1,   stall: 1'b0, exp_beats: 1,   exp_cnt: 1};
    vecs[3] = '{len: 6,   stall: 1'b1, exp_beats: 6,   exp_cnt: 6};
    vecs[4] = '{len: 255, stall: 1'b0, exp_beats: 255, exp_cnt: 255};

    i_len = 8'd0; i_a_v = 1'b0; i_a_d = 8'd0; i_z_r = 1'b1;
    stall_mode = 1'b0;
    clear_counts();
    do_reset();

    // Reset state and idle with no traffic
    repeat (2) tick();

    // Table-driven bursts with continuous upstream traffic
    i_a_v = 1'b1;
    for (int v = 0; v < 5; v++) begin
      clear_counts();
      stall_mode = vecs[v].stall;
      i_len = 8'(vecs[v].len);
      i_go  = 1'b1;
      run_until(1, 4 * vecs[v].len + 20);
      repeat (3) tick();
      chk("vec_beats", n_beats, vecs[v].exp_beats);
      chk("vec_last",  n_last,  1);
      chk("vec_done",  n_done,  1);
      chk("vec_cnt",   o_cnt,   vecs[v].exp_cnt);
      $display("vector %0d len=%0d stall=%0d beats=%0d cnt=%0d", v, vecs[v].len, vecs[v].stall, n_beats, o_cnt);
    end
    stall_mode = 1'b0;

    // Zero-length go: done next cycle, never busy
    clear_counts();
    i_len = 8'd0;
    i_go  = 1'b1;
    repeat (4) tick();
    chk("len0_done", n_done, 1);
    chk("len0_beats", n_beats, 0);
    $display("len0 done=%0d", n_done);

    // Back-to-back: go held high during the first burst starts the second
    // on the done cycle
    clear_counts();
    i_len = 8'd2;
    i_go  = 1'b1;
    tick();
    i_go  = 1'b1;
    i_len = 8'd5;
    run_until(2, 60);
    repeat (2) tick();
    chk("b2b_beats", n_beats, 7);
    chk("b2b_last",  n_last,  2);
    chk("b2b_done",  n_done,  2);
    chk("b2b_cnt",   o_cnt,   5);
    $display("back2back beats=%0d lasts=%0d dones=%0d", n_beats, n_last, n_done);

    // W=4 instance, maximum length 15
    do_reset();
    clear_counts();
    i_len = 8'd15;
    i_go  = 1'b1;
    run_until(1, 60);
    repeat (2) tick();
    chk("w4_beats", n4_beats, 15);
    chk("w4_last",  n4_last,  1);
    chk("w4_cnt",   d4_cnt,   15);
    chk("w4_ref_beats", n_beats, 15);
    $display("w4 beats=%0d cnt=%0d", n4_beats, d4_cnt);

    // Reset mid-burst with a beat held in the output slot
    clear_counts();
    i_len = 8'd5;
    i_go  = 1'b1;
    repeat (3) tick();
    chk("mid_zv",  o_z_v, 1);
    chk("mid_cnt", o_cnt, 2);
    do_reset();
    repeat (3) tick();
    chk("mid_nodone", n_done, 0);
    i_len = 8'd1;
    i_go  = 1'b1;
    run_until(1, 20);
    repeat (2) tick();
    chk("mid_after_cnt",  o_cnt,  1);
    chk("mid_after_done", n_done, 1);
    $display("reset mid-burst then len1 done=%0d cnt=%0d", n_done, o_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
